// File: rtl/call_stack.sv
// Return-address LIFO for a program sequencer: push on call, pop on return.
// A pop registers the top entry onto address and pulses load low for one cycle.
module call_stack #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DEPTH         = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [ADDRESS_WIDTH-1:0]   push_address,
    input  logic                       pop,
    output logic [ADDRESS_WIDTH-1:0]   address,
    output logic                       load,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    logic [ADDRESS_WIDTH-1:0] entries [DEPTH];
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            top_ptr;
    logic                     do_pop;
    logic                     do_push;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);

    // wr_ptr aliases to 0 when full, but a push is only accepted there together with a pop.
    assign wr_ptr  = count[PW-1:0];
    assign top_ptr = wr_ptr - PTR_ONE;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            count     <= '0;
            address   <= '0;
            load      <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            load <= !do_pop;
            if (do_pop) begin
                address <= entries[top_ptr];
            end

            // A combined push/pop replaces the top entry in place.
            if (do_push && do_pop) begin
                entries[top_ptr] <= push_address;
            end else if (do_push) begin
                entries[wr_ptr] <= push_address;
            end

            if (do_push && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count <= count - CNT_ONE;
            end

            if (push && !do_push) begin
                overflow <= 1'b1;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench for call_stack: directed scenarios plus randomized traffic
// compared against a queue-based LIFO model.
module tb_call_stack;

    localparam int AW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          push  = 1'b0;
    logic          pop   = 1'b0;
    logic [AW-1:0] push_address = '0;
    logic [AW-1:0] address;
    logic          load;
    logic [CW-1:0] count;
    logic          empty, full, overflow, underflow;

    call_stack #(.ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .push(push), .push_address(push_address),
        .pop(pop), .address(address), .load(load), .count(count),
        .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    // Downstream counter_w_load stand-in with enable tied high.
    logic [AW-1:0] ctr = '0;
    always_ff @(posedge clock) begin
        if (!load) ctr <= address;
        else       ctr <= ctr + 16'd1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a plain queue with the top at the back.
    logic [AW-1:0] mq[$];
    logic [AW-1:0] m_addr = '0;
    logic          m_load = 1'b1;
    logic          m_ovf  = 1'b0;
    logic          m_unf  = 1'b0;

    task automatic cyc(input logic r, input logic pu, input logic [AW-1:0] pa, input logic po);
        reset = r; push = pu; push_address = pa; pop = po;
        @(posedge clock);
        if (r) begin
            mq.delete(); m_addr = '0; m_load = 1'b1; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            m_load = 1'b1;
            if (po) begin
                if (mq.size() > 0) begin
                    m_addr = mq.pop_back();
                    m_load = 1'b0;
                end else begin
                    m_unf = 1'b1;
                end
            end
            if (pu) begin
                if (mq.size() < DEPTH) mq.push_back(pa);
                else m_ovf = 1'b1;
            end
        end
        #1;
        reset = 1'b0; push = 1'b0; pop = 1'b0;
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b1, 16'h1234, 1'b1);
        n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_bad++; $display("FAIL reset_empty_full got %b%b want 10", empty, full); end
        n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_bad++; $display("FAIL reset_flags got %b%b want 00", overflow, underflow); end
        n_cmp++; if (load !== 1'b1 || address !== '0) begin n_bad++; $display("FAIL reset_out got load=%b addr=%h want 1/0000", load, address); end
    endtask

    task automatic test_basic();
        cyc(1'b1, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b1, 16'h0010, 1'b0);
        cyc(1'b0, 1'b1, 16'h0020, 1'b0);
        cyc(1'b0, 1'b1, 16'h0030, 1'b0);
        n_cmp++; if (count !== 4'd3) begin n_bad++; $display("FAIL basic_count got %0d want 3", count); end
        cyc(1'b0, 1'b0, '0, 1'b1);
        n_cmp++; if (address !== 16'h0030 || load !== 1'b0) begin n_bad++; $display("FAIL basic_pop got addr=%h load=%b want 0030/0", address, load); end
        n_cmp++; if (count !== 4'd2) begin n_bad++; $display("FAIL basic_count_pop got %0d want 2", count); end
        cyc(1'b0, 1'b0, '0, 1'b0);
        n_cmp++; if (load !== 1'b1 || address !== 16'h0030) begin n_bad++; $display("FAIL basic_hold got addr=%h load=%b want 0030/1", address, load); end
    endtask

    task automatic test_fill_overflow();
        cyc(1'b1, 1'b0, '0, 1'b0);
        for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b1, AW'(i), 1'b0);
        n_cmp++; if (full !== 1'b1 || count !== 4'd8) begin n_bad++; $display("FAIL fill_full got full=%b count=%0d want 1/8", full, count); end
        cyc(1'b0, 1'b1, 16'h0009, 1'b0);
        n_cmp++; if (overflow !== 1'b1 || count !== 4'd8) begin n_bad++; $display("FAIL fill_overflow got ovf=%b count=%0d want 1/8", overflow, count); end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, '0, 1'b1);
            n_cmp++;
            if (address !== AW'(8 - i) || load !== 1'b0) begin
                n_bad++; $display("FAIL fill_pop%0d got addr=%h load=%b want %h/0", i, address, load, AW'(8 - i));
            end
        end
        n_cmp++; if (empty !== 1'b1 || overflow !== 1'b1 || underflow !== 1'b0) begin n_bad++; $display("FAIL fill_end got empty=%b ovf=%b unf=%b want 1/1/0", empty, overflow, underflow); end
    endtask

    task automatic test_underflow();
        cyc(1'b1, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1);
        n_cmp++; if (underflow !== 1'b1 || load !== 1'b1) begin n_bad++; $display("FAIL underflow got unf=%b load=%b want 1/1", underflow, load); end
        n_cmp++; if (address !== '0 || empty !== 1'b1 || count !== '0) begin n_bad++; $display("FAIL underflow_state got addr=%h empty=%b count=%0d want 0000/1/0", address, empty, count); end
        cyc(1'b0, 1'b0, '0, 1'b0);
        n_cmp++; if (underflow !== 1'b1) begin n_bad++; $display("FAIL underflow_sticky got %b want 1", underflow); end
    endtask

    task automatic test_push_pop_same();
        cyc(1'b1, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b1, 16'h0100, 1'b0);
        cyc(1'b0, 1'b1, 16'h0200, 1'b1);
        n_cmp++; if (address !== 16'h0100 || load !== 1'b0 || count !== 4'd1) begin n_bad++; $display("FAIL pushpop got addr=%h load=%b count=%0d want 0100/0/1", address, load, count); end
        cyc(1'b0, 1'b0, '0, 1'b0);
        n_cmp++; if (load !== 1'b1) begin n_bad++; $display("FAIL pushpop_single got load=%b want 1", load); end
        cyc(1'b0, 1'b0, '0, 1'b1);
        n_cmp++; if (address !== 16'h0200 || count !== '0) begin n_bad++; $display("FAIL pushpop_later got addr=%h count=%0d want 0200/0", address, count); end
        cyc(1'b1, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b1, 16'h0077, 1'b1);
        n_cmp++; if (count !== 4'd1 || underflow !== 1'b1 || load !== 1'b1 || address !== '0) begin n_bad++; $display("FAIL pushpop_empty got count=%0d unf=%b load=%b addr=%h want 1/1/1/0000", count, underflow, load, address); end
    endtask

    task automatic test_reset_cancel();
        cyc(1'b1, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1);
        cyc(1'b0, 1'b1, 16'h00AA, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1);
        n_cmp++; if (load !== 1'b0) begin n_bad++; $display("FAIL cancel_pre got load=%b want 0", load); end
        cyc(1'b1, 1'b0, '0, 1'b0);
        n_cmp++; if (load !== 1'b1 || count !== '0 || underflow !== 1'b0 || overflow !== 1'b0 || address !== '0) begin n_bad++; $display("FAIL cancel got load=%b count=%0d unf=%b ovf=%b addr=%h want 1/0/0/0/0000", load, count, underflow, overflow, address); end
    endtask

    task automatic test_counter();
        cyc(1'b1, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b1, 16'd55, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b0);
        n_cmp++; if (ctr !== 16'd55) begin n_bad++; $display("FAIL counter_load got %0d want 55", ctr); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] vals [4];
        cyc(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            vals[i] = AW'($urandom);
            cyc(1'b0, 1'b1, vals[i], 1'b0);
        end
        for (int i = 3; i >= 0; i--) begin
            cyc(1'b0, 1'b0, '0, 1'b1);
            n_cmp++;
            if (address !== vals[i] || load !== 1'b0) begin
                n_bad++; $display("FAIL b2b_pop%0d got addr=%h load=%b want %h/0", i, address, load, vals[i]);
            end
        end
    endtask

    task automatic test_random();
        cyc(1'b1, 1'b0, '0, 1'b0);
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 99) < 55), AW'($urandom),
                ($urandom_range(0, 99) < 45));
            n_cmp++;
            if (address !== m_addr || load !== m_load) begin
                n_bad++; $display("FAIL rnd_out@%0d got addr=%h load=%b want %h/%b", n, address, load, m_addr, m_load);
            end
            n_cmp++;
            if (count !== CW'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin
                n_bad++; $display("FAIL rnd_count@%0d got count=%0d empty=%b full=%b want %0d", n, count, empty, full, mq.size());
            end
            n_cmp++;
            if (overflow !== m_ovf || underflow !== m_unf) begin
                n_bad++; $display("FAIL rnd_flags@%0d got ovf=%b unf=%b want %b/%b", n, overflow, underflow, m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_overflow();
        test_underflow();
        test_push_pop_same();
        test_reset_cancel();
        test_counter();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
